program_loader: RTL and testbench

Byte-stream program loader that writes 16-bit instructions into the CPU's program memory through the CPU's download interface (`download_program`, `instruction_index`, `program_in`). It sits between a byte source (UART receiver or host bridge) and the CPU. It parses a framed load command and issues one single-cycle write per instruction halfword. A trailing checksum validates the whole frame.

---
 rtl/program_loader.sv | 185 ++++++++++++++++++
 tb/tb_program_loader.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Parses framed byte-stream load commands and writes 16-bit instructions into CPU program memory.
// Frame: SYNC, base index (4B LE), count N (2B LE), N halfwords (lo, hi), XOR checksum byte.
module program_loader #(
    parameter int unsigned INDEX_W        = 32,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               download_program,
    output logic [INDEX_W-1:0] instruction_index,
    output logic [15:0]        program_in,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [15:0]        word_count
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StCnt,
        StDlo,
        StDhi,
        StWrite,
        StCheck
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [31:0]        base_q, base_d;
    logic [15:0]        count_q, count_d;
    logic [7:0]         lo_q, lo_d;
    logic [7:0]         xor_q, xor_d;
    logic [15:0]        wc_q, wc_d;
    logic [INDEX_W-1:0] idx_q, idx_d;
    logic [15:0]        data_q, data_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            byte_cnt_q <= '0;
            base_q     <= '0;
            count_q    <= '0;
            lo_q       <= '0;
            xor_q      <= '0;
            wc_q       <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            base_q     <= base_d;
            count_q    <= count_d;
            lo_q       <= lo_d;
            xor_q      <= xor_d;
            wc_q       <= wc_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            done_q     <= done_d;
            error_q    <= error_d;
            timer_q    <= timer_d;
        end
    end

    assign xfer = rx_valid && rx_ready;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        base_d     = base_q;
        count_d    = count_q;
        lo_d       = lo_q;
        xor_d      = xor_q;
        wc_d       = wc_q;
        idx_d      = idx_q;
        data_d     = data_q;
        done_d     = 1'b0;
        error_d    = error_q;
        timer_d    = timer_q;

        unique case (state_q)
            StIdle: begin
                if (xfer && rx_data == SYNC_BYTE) begin
                    state_d    = StAddr;
                    byte_cnt_d = '0;
                    error_d    = 1'b0;
                    wc_d       = '0;
                    xor_d      = '0;
                end
            end
            StAddr: begin
                if (xfer) begin
                    base_d     = {rx_data, base_q[31:8]};
                    xor_d      = xor_q ^ rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        byte_cnt_d = '0;
                        state_d    = StCnt;
                    end
                end
            end
            StCnt: begin
                if (xfer) begin
                    count_d = {rx_data, count_q[15:8]};
                    xor_d   = xor_q ^ rx_data;
                    if (byte_cnt_q == 2'd1) begin
                        byte_cnt_d = '0;
                        state_d    = (count_d == 16'd0) ? StCheck : StDlo;
                    end else begin
                        byte_cnt_d = 2'd1;
                    end
                end
            end
            StDlo: begin
                if (xfer) begin
                    lo_d    = rx_data;
                    xor_d   = xor_q ^ rx_data;
                    state_d = StDhi;
                end
            end
            StDhi: begin
                // Address and data are registered here so they hold after the strobe.
                if (xfer) begin
                    idx_d   = INDEX_W'(base_q) + INDEX_W'(wc_q);
                    data_d  = {rx_data, lo_q};
                    xor_d   = xor_q ^ rx_data;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                wc_d    = wc_q + 16'd1;
                state_d = (wc_q + 16'd1 == count_q) ? StCheck : StDlo;
            end
            StCheck: begin
                if (xfer) begin
                    if (rx_data == xor_q) begin
                        done_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Inter-byte stall watchdog; idle and the write cycle never count.
        if (state_q inside {StAddr, StCnt, StDlo, StDhi, StCheck}) begin
            if (xfer) begin
                timer_d = '0;
            end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                timer_d = '0;
                state_d = StIdle;
                error_d = 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end else begin
            timer_d = '0;
        end
    end

    assign rx_ready          = (state_q != StWrite) && !rst;
    assign download_program  = (state_q == StWrite);
    assign instruction_index = idx_q;
    assign program_in        = data_q;
    assign busy              = (state_q != StIdle);
    assign done              = done_q;
    assign error             = error_q;
    assign word_count        = wc_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table-driven frames, random frames against a
// frame-parsing reference model, and hand-written timeout / mid-frame reset sequences.
module tb_program_loader;

    localparam int unsigned INDEX_W = 32;
    localparam int unsigned TMO     = 16;
    localparam int          MAXB    = 32;

    typedef struct {
        logic [7:0]  b [MAXB];
        int          len;
        bit          exp_done;
        bit          exp_err;
        int          exp_wc;
        int          exp_nwr;
        logic [31:0] f_idx;
        logic [15:0] f_dat;
        logic [31:0] l_idx;
        logic [15:0] l_dat;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               rx_ready;
    logic               download_program;
    logic [INDEX_W-1:0] instruction_index;
    logic [15:0]        program_in;
    logic               busy;
    logic               done;
    logic               error;
    logic [15:0]        word_count;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] got_idx[$];
    logic [15:0] got_dat[$];
    int          done_cycles = 0;

    logic [31:0] m_idx[$];
    logic [15:0] m_dat[$];
    bit          m_done;
    int          m_wc;

    vec_t vt[5];

    program_loader #(
        .INDEX_W       (INDEX_W),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .download_program (download_program),
        .instruction_index(instruction_index),
        .program_in       (program_in),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .word_count       (word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Write/done monitor, sampled 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        if (download_program === 1'b1) begin
            got_idx.push_back(instruction_index);
            got_dat.push_back(program_in);
        end
        if (done === 1'b1) done_cycles++;
        if (rst === 1'b0) check("rx_ready_vs_write", 64'(rx_ready), 64'(!download_program));
    end

    // Reference model: parse the frame bytes directly.
    task automatic model(input vec_t v);
        int          i;
        int          n;
        logic [31:0] base;
        logic [7:0]  x;
        m_idx.delete();
        m_dat.delete();
        i = 0;
        while (i < v.len && v.b[i] != 8'hA5) i++;
        base = {v.b[i+4], v.b[i+3], v.b[i+2], v.b[i+1]};
        n    = int'({v.b[i+6], v.b[i+5]});
        x    = 8'h00;
        for (int j = i + 1; j <= i + 6 + 2 * n; j++) x = x ^ v.b[j];
        for (int k = 0; k < n; k++) begin
            m_idx.push_back(base + 32'(k));
            m_dat.push_back({v.b[i+8+2*k], v.b[i+7+2*k]});
        end
        m_done = (v.b[i+7+2*n] == x);
        m_wc   = n;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        guard    = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_vec++;
            n_bad++;
            $display("FAIL rx_ready_wait: got never-ready, expected ready within 100 cycles");
        end
        @(negedge clk);
        if (gap > 0) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            repeat (gap) @(negedge clk);
        end
    endtask

    function automatic vec_t mk(input logic [255:0] bytes, input int len, input bit d,
                                input bit e, input int wc, input int nwr,
                                input logic [31:0] fi, input logic [15:0] fd,
                                input logic [31:0] li, input logic [15:0] ld);
        vec_t v;
        for (int i = 0; i < MAXB; i++) begin
            if (i < len) v.b[i] = bytes[8*(len-1-i) +: 8];
            else         v.b[i] = 8'h00;
        end
        v.len = len; v.exp_done = d; v.exp_err = e; v.exp_wc = wc; v.exp_nwr = nwr;
        v.f_idx = fi; v.f_dat = fd; v.l_idx = li; v.l_dat = ld;
        return v;
    endfunction

    function automatic vec_t rnd_vec();
        vec_t       v;
        int         p;
        int         n;
        logic [7:0] x;
        logic [7:0] bb;
        p = 0;
        x = 8'h00;
        for (int i = 0; i < MAXB; i++) v.b[i] = 8'h00;
        for (int s = 0; s < int'($urandom_range(0, 2)); s++) begin
            bb = 8'($urandom);
            if (bb == 8'hA5) bb = 8'h00;
            v.b[p] = bb; p++;
        end
        v.b[p] = 8'hA5; p++;
        for (int i = 0; i < 4; i++) begin
            bb = 8'($urandom); v.b[p] = bb; p++; x = x ^ bb;
        end
        n = int'($urandom_range(0, 5));
        v.b[p] = 8'(n); p++; x = x ^ 8'(n);
        v.b[p] = 8'h00; p++;
        for (int i = 0; i < 2 * n; i++) begin
            bb = 8'($urandom); v.b[p] = bb; p++; x = x ^ bb;
        end
        if ($urandom_range(0, 1) == 1) v.b[p] = x;
        else                           v.b[p] = x ^ 8'($urandom_range(1, 255));
        p++;
        v.len = p;
        v.exp_done = 1'b0; v.exp_err = 1'b0; v.exp_wc = 0; v.exp_nwr = 0;
        v.f_idx = '0; v.f_dat = '0; v.l_idx = '0; v.l_dat = '0;
        return v;
    endfunction

    task automatic run_frame(input vec_t v, input int max_gap, input bit use_tbl,
                             input string name);
        bit ed;
        bit ee;
        int ew;
        int nw;
        model(v);
        got_idx.delete();
        got_dat.delete();
        done_cycles = 0;
        for (int i = 0; i < v.len; i++)
            send_byte(v.b[i], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
        rx_valid = 1'b0;
        repeat (4) @(negedge clk);
        ed = use_tbl ? v.exp_done : m_done;
        ee = use_tbl ? v.exp_err : !m_done;
        ew = use_tbl ? v.exp_wc : m_wc;
        check({name, " done_pulses"}, 64'(done_cycles), ed ? 64'd1 : 64'd0);
        check({name, " error"}, 64'(error), 64'(ee));
        check({name, " busy"}, 64'(busy), 64'd0);
        check({name, " word_count"}, 64'(word_count), 64'(ew));
        check({name, " n_writes"}, 64'(got_idx.size()), 64'(m_idx.size()));
        nw = (got_idx.size() < m_idx.size()) ? got_idx.size() : m_idx.size();
        for (int i = 0; i < nw; i++) begin
            check({name, " write_idx"}, 64'(got_idx[i]), 64'(m_idx[i]));
            check({name, " write_dat"}, 64'(got_dat[i]), 64'(m_dat[i]));
        end
        if (use_tbl) begin
            check({name, " tbl_n_writes"}, 64'(got_idx.size()), 64'(v.exp_nwr));
            if (v.exp_nwr > 0 && got_idx.size() > 0) begin
                check({name, " first_idx"}, 64'(got_idx[0]), 64'(v.f_idx));
                check({name, " first_dat"}, 64'(got_dat[0]), 64'(v.f_dat));
                check({name, " last_idx"}, 64'(got_idx[got_idx.size()-1]), 64'(v.l_idx));
                check({name, " last_dat"}, 64'(got_dat[got_dat.size()-1]), 64'(v.l_dat));
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = mk(256'h00_3C_A5_0A_00_00_00_02_00_05_20_C2_1F_F0, 14, 1, 0, 2, 2,
                   32'd10, 16'h2005, 32'd11, 16'h1FC2);
        vt[1] = mk(256'hA5_0A_00_00_00_02_00_05_20_C2_1F_00, 12, 0, 1, 2, 2,
                   32'd10, 16'h2005, 32'd11, 16'h1FC2);
        vt[2] = mk(256'hA5_0A_00_00_00_02_00_05_20_C2_1F_F0, 12, 1, 0, 2, 2,
                   32'd10, 16'h2005, 32'd11, 16'h1FC2);
        vt[3] = mk(256'hA5_00_00_00_00_00_00_00, 8, 1, 0, 0, 0,
                   32'd0, 16'h0, 32'd0, 16'h0);
        vt[4] = mk(256'hA5_FF_FF_FF_FF_02_00_01_00_02_00_01, 12, 1, 0, 2, 2,
                   32'hFFFF_FFFF, 16'h0001, 32'h0000_0000, 16'h0002);

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst rx_ready", 64'(rx_ready), 64'd0);
        check("rst download_program", 64'(download_program), 64'd0);
        check("rst instruction_index", 64'(instruction_index), 64'd0);
        check("rst program_in", 64'(program_in), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst error", 64'(error), 64'd0);
        check("rst word_count", 64'(word_count), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst rx_ready", 64'(rx_ready), 64'd1);

        // Continuous rx_valid: back-pressure comes only from the write cycle.
        for (int i = 0; i < 5; i++) run_frame(vt[i], 0, 1'b1, $sformatf("tbl%0d", i));

        for (int i = 0; i < 20; i++) run_frame(rnd_vec(), 3, 1'b0, $sformatf("rnd%0d", i));

        // Stall after two bytes; abort lands on the 16th idle edge.
        got_idx.delete();
        got_dat.delete();
        send_byte(8'hA5, 0);
        send_byte(8'h0A, 0);
        rx_valid = 1'b0;
        repeat (TMO - 1) @(negedge clk);
        check("tmo pre busy", 64'(busy), 64'd1);
        check("tmo pre error", 64'(error), 64'd0);
        @(negedge clk);
        check("tmo error", 64'(error), 64'd1);
        check("tmo busy", 64'(busy), 64'd0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("tmo no_writes", 64'(got_idx.size()), 64'd0);
        check("tmo error_sticky", 64'(error), 64'd1);

        // Reset while waiting for the high byte cancels the pending write.
        send_byte(8'hA5, 0);
        send_byte(8'h10, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h34, 0);
        got_idx.delete();
        got_dat.delete();
        rx_data = 8'h12;
        rst     = 1'b1;
        @(negedge clk);
        check("mid_rst download_program", 64'(download_program), 64'd0);
        check("mid_rst instruction_index", 64'(instruction_index), 64'd0);
        check("mid_rst program_in", 64'(program_in), 64'd0);
        check("mid_rst busy", 64'(busy), 64'd0);
        check("mid_rst done", 64'(done), 64'd0);
        check("mid_rst error", 64'(error), 64'd0);
        check("mid_rst word_count", 64'(word_count), 64'd0);
        check("mid_rst rx_ready", 64'(rx_ready), 64'd0);
        rst      = 1'b0;
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst no_writes", 64'(got_idx.size()), 64'd0);
        check("mid_rst idle busy", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
